// File: rtl/acc_drain.sv
// acc_drain: snapshots a PE row's accumulators, clears them, and streams them out one per beat
module acc_drain #(
  parameter int N_PE  = 8,
  parameter int ACC_W = 32,
  localparam int IDX_W = (N_PE > 1) ? $clog2(N_PE) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_PE*ACC_W-1:0]   acc_in,
  input  logic                    drain_start,
  output logic                    pe_clr,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [ACC_W-1:0] m_data,
  output logic [IDX_W-1:0]        m_idx,
  output logic                    m_last,
  output logic                    busy,
  output logic                    done,
  output logic                    err_overrun
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_PE - 1);
  typedef enum logic {IDLE, SEND} state_t;
  state_t                  state_q;
  logic signed [ACC_W-1:0] snap_q [N_PE];
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic signed [ACC_W-1:0] data_q;
  logic                    clr_q, valid_q, last_q, busy_q, done_q, err_q;
  // index of the beat that follows the current one
  always_comb idx_d = idx_q + 1'b1;
  // drain FSM: capture on start, then one beat per handshake; every output is a register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      for (int i = 0; i < N_PE; i++) snap_q[i] <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      clr_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      clr_q  <= 1'b0;
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (drain_start) begin
          for (int i = 0; i < N_PE; i++) snap_q[i] <= acc_in[i*ACC_W +: ACC_W];
          state_q <= SEND;
          idx_q   <= '0;
          data_q  <= acc_in[0 +: ACC_W];
          last_q  <= (N_PE == 1);
          clr_q   <= 1'b1;
          valid_q <= 1'b1;
          busy_q  <= 1'b1;
        end
      end else begin
        if (drain_start) err_q <= 1'b1;
        if (m_ready) begin
          if (idx_q == LAST) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            idx_q  <= idx_d;
            data_q <= snap_q[idx_d];
            last_q <= (idx_d == LAST);
          end
        end
      end
    end
  end
  assign pe_clr      = clr_q;
  assign m_valid     = valid_q;
  assign m_data      = data_q;
  assign m_idx       = idx_q;
  assign m_last      = last_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_overrun = err_q;
endmodule
